// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared types and helpers for the icache refill path. It holds
//             the refill arbiter state encoding, the line geometry
//             derivations and a small popcount helper.
//  Revision : 1.0  initial release
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    // Line size in bits for a line of the given size in bytes.
    function automatic int calc_line_bits(input int line_bytes);
        return line_bytes * 8;
    endfunction

    // Number of byte-offset bits inside a line.
    function automatic int calc_offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Population count over up to eight requesters.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. The search starts at ptr and
//             wraps modulo N. The first asserted request wins.
//  Ports    : req   - request vector
//             ptr   - highest-priority position for this evaluation
//             grant - one-hot winner (all zero if no request)
//             index - binary winner index (0 if no request)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand[IW-1:0]]) begin
                found              = 1'b1;
                grant[cand[IW-1:0]] = 1'b1;
                index              = cand[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_arbiter
//  Purpose  : Shares one line-refill port among NUM_REQ icache miss ports.
//             Misses are granted round-robin, and one refill is kept in
//             flight at a time. The returned line goes to every requester
//             still missing on that line address.
//  Ports    : clk, rst_n (async, active-low)
//             req_valid/req_addr/req_ready   - per-cache miss interface
//             resp_valid/resp_data           - line delivery (shared data)
//             mem_req_*/mem_resp_*           - memory controller refill port
//             busy, refill_count, coalesce_count - status
//  Revision : 1.0  initial release
// ============================================================================
module icache_refill_arbiter
    import icache_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LINE_BYTES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*32-1:0]     req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [LINE_BYTES*8-1:0]   resp_data,
    output logic                      mem_req_valid,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0]   mem_resp_data,
    output logic                      busy,
    output logic [15:0]               refill_count,
    output logic [15:0]               coalesce_count
);

    localparam int LINE_BITS   = calc_line_bits(LINE_BYTES);
    localparam int OFFSET_BITS = calc_offset_bits(LINE_BYTES);
    localparam int TAG_W       = 32 - OFFSET_BITS;
    localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    arb_state_t           state;
    logic [IW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   gnt_onehot;

    logic [NUM_REQ-1:0]   win_grant;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        next_ptr;
    logic [31:0]          win_addr;
    logic [NUM_REQ-1:0]   hit_mask;
    logic [3:0]           extra_cnt;
    logic [16:0]          coalesce_sum;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .index (win_idx)
    );

    // Address of the arbitration winner. It is only meaningful when some
    // req_valid is set.
    always_comb begin
        win_addr = req_addr[32*int'(win_idx) +: 32];
    end

    assign next_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

    // Delivery mask. Every requester still valid on the in-flight line
    // receives it. This includes the granted one, and only if it has not
    // withdrawn.
    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_mask[i] = req_valid[i] &&
                (req_addr[32*i + OFFSET_BITS +: TAG_W] == mem_req_addr[31:OFFSET_BITS]);
        end
    end

    assign extra_cnt    = popcount8(8'(hit_mask & ~gnt_onehot));
    assign coalesce_sum = {1'b0, coalesce_count} + 17'(extra_cnt);

    // Status outputs decode the state register directly, so they carry no
    // input-to-output path.
    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gnt_onehot     <= '0;
            mem_req_addr   <= '0;
            req_ready      <= '0;
            resp_valid     <= '0;
            resp_data      <= '0;
            refill_count   <= '0;
            coalesce_count <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_onehot   <= win_grant;
                        mem_req_addr <= win_addr & LINE_MASK;
                        req_ready    <= win_grant;
                        rr_ptr       <= next_ptr;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        if (refill_count != 16'hFFFF) begin
                            refill_count <= refill_count + 16'd1;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        resp_data      <= mem_resp_data;
                        resp_valid     <= hit_mask;
                        coalesce_count <= coalesce_sum[16] ? 16'hFFFF : coalesce_sum[15:0];
                        state          <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // LINE_BITS documents the data width. The port uses the same expression.
    logic unused_ok;
    assign unused_ok = (LINE_BITS == LINE_BYTES * 8);

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_refill_arbiter
//  Purpose  : Directed self-checking bench for icache_refill_arbiter. It
//             covers a single refill, round-robin order, coalescing, memory
//             backpressure, abandonment, stray responses and asynchronous
//             reset in mid-refill.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_refill_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LINE_BYTES = 32;
    localparam int LB         = LINE_BYTES * 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*32-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [LB-1:0]         resp_data;
    logic                  mem_req_valid;
    logic [31:0]           mem_req_addr;
    logic                  mem_req_ready = 1'b0;
    logic                  mem_resp_valid = 1'b0;
    logic [LB-1:0]         mem_resp_data = '0;
    logic                  busy;
    logic [15:0]           refill_count;
    logic [15:0]           coalesce_count;

    int n_cmp = 0;
    int n_err = 0;

    icache_refill_arbiter #(.NUM_REQ(NUM_REQ), .LINE_BYTES(LINE_BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .refill_count   (refill_count),
        .coalesce_count (coalesce_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        req_valid      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_addr(input int i, input logic [31:0] a);
        req_addr[32*i +: 32] = a;
    endtask

    // Bounded wait for the next grant pulse, then compare it.
    task automatic wait_grant(input string tag, input logic [3:0] exp_gnt, input logic [31:0] exp_addr);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (req_ready == '0 && k < 20);
        check({tag, "_req_ready"}, LB'(req_ready), LB'(exp_gnt));
        check({tag, "_mem_addr"}, LB'(mem_req_addr), LB'(exp_addr));
        check({tag, "_mem_req_valid"}, LB'(mem_req_valid), LB'(1'b1));
    endtask

    // Full refill: grant, zero-wait accept, immediate response, drop.
    task automatic refill(input string tag, input logic [3:0] exp_gnt, input logic [31:0] exp_addr,
                          input logic [LB-1:0] data, input logic [3:0] exp_resp, input logic [3:0] drop);
        wait_grant(tag, exp_gnt, exp_addr);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        step();
        mem_resp_valid = 1'b0;
        check({tag, "_resp_valid"}, LB'(resp_valid), LB'(exp_resp));
        check({tag, "_resp_data"}, resp_data, data);
        req_valid = req_valid & ~drop;
        step();
    endtask

    initial begin
        logic [LB-1:0] d;

        // ---------------- reset state ----------------
        apply_reset();
        check("rst_req_ready", LB'(req_ready), '0);
        check("rst_resp_valid", LB'(resp_valid), '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_mem_req_valid", LB'(mem_req_valid), '0);
        check("rst_mem_req_addr", LB'(mem_req_addr), '0);
        check("rst_busy", LB'(busy), '0);
        check("rst_refill_count", LB'(refill_count), '0);
        check("rst_coalesce_count", LB'(coalesce_count), '0);

        // ---------------- single request ----------------
        set_addr(0, 32'h0000_1234);
        req_valid = 4'b0001;
        step();
        check("single_req_ready", LB'(req_ready), LB'(4'b0001));
        check("single_mem_req_valid", LB'(mem_req_valid), LB'(1'b1));
        check("single_mem_addr", LB'(mem_req_addr), LB'(32'h0000_1220));
        check("single_busy", LB'(busy), LB'(1'b1));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("single_wait_req_ready", LB'(req_ready), '0);
        check("single_wait_mem_req_valid", LB'(mem_req_valid), '0);
        check("single_refill_count", LB'(refill_count), LB'(16'd1));
        step();
        step();
        d = {8{32'hC0DE_0001}};
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        step();
        mem_resp_valid = 1'b0;
        check("single_resp_valid", LB'(resp_valid), LB'(4'b0001));
        check("single_resp_data", resp_data, d);
        req_valid = 4'b0000;
        step();
        check("single_idle_resp_valid", LB'(resp_valid), '0);
        check("single_idle_busy", LB'(busy), '0);

        // ---------------- round-robin ----------------
        apply_reset();
        set_addr(0, 32'h0000_1000);
        set_addr(1, 32'h0000_2000);
        set_addr(2, 32'h0000_3000);
        set_addr(3, 32'h0000_4000);
        req_valid = 4'b1111;
        refill("rr0", 4'b0001, 32'h0000_1000, {8{32'h1111_0000}}, 4'b0001, 4'b0001);
        refill("rr1", 4'b0010, 32'h0000_2000, {8{32'h2222_0000}}, 4'b0010, 4'b0010);
        refill("rr2", 4'b0100, 32'h0000_3000, {8{32'h3333_0000}}, 4'b0100, 4'b0100);
        refill("rr3", 4'b1000, 32'h0000_4000, {8{32'h4444_0000}}, 4'b1000, 4'b1000);
        check("rr_refill_count", LB'(refill_count), LB'(16'd4));
        // The pointer has wrapped to 0, so requester 0 must beat requester 3.
        req_valid = 4'b1001;
        refill("rr_wrap0", 4'b0001, 32'h0000_1000, {8{32'h5555_0000}}, 4'b0001, 4'b0001);
        refill("rr_wrap3", 4'b1000, 32'h0000_4000, {8{32'h6666_0000}}, 4'b1000, 4'b1000);
        check("rr_coalesce_count", LB'(coalesce_count), '0);

        // ---------------- coalescing ----------------
        apply_reset();
        set_addr(0, 32'h0000_0100);
        set_addr(2, 32'h0000_011C);
        req_valid = 4'b0001;
        wait_grant("coal", 4'b0001, 32'h0000_0100);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        req_valid = 4'b0101;
        step();
        check("coal_no_grant2", LB'(req_ready), '0);
        d = {8{32'hBEEF_0100}};
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        step();
        mem_resp_valid = 1'b0;
        check("coal_resp_valid", LB'(resp_valid), LB'(4'b0101));
        check("coal_resp_data", resp_data, d);
        check("coal_coalesce_count", LB'(coalesce_count), LB'(16'd1));
        check("coal_refill_count", LB'(refill_count), LB'(16'd1));
        req_valid = 4'b0000;
        step();
        check("coal_idle_req_ready", LB'(req_ready), '0);

        // ---------------- backpressure ----------------
        set_addr(1, 32'h0000_2040);
        set_addr(3, 32'h0000_3000);
        req_valid = 4'b1010;
        wait_grant("bp", 4'b0010, 32'h0000_2040);
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_hold_valid", LB'(mem_req_valid), LB'(1'b1));
            check("bp_hold_addr", LB'(mem_req_addr), LB'(32'h0000_2040));
            check("bp_no_grant", LB'(req_ready), '0);
        end
        check("bp_refill_count_held", LB'(refill_count), LB'(16'd1));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        d = {8{32'hABCD_2040}};
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        step();
        mem_resp_valid = 1'b0;
        check("bp_resp_valid", LB'(resp_valid), LB'(4'b0010));
        req_valid = 4'b1000;
        step();
        refill("bp3", 4'b1000, 32'h0000_3000, {8{32'h7777_3000}}, 4'b1000, 4'b1000);
        check("bp_refill_count", LB'(refill_count), LB'(16'd3));

        // ---------------- abandonment ----------------
        set_addr(0, 32'h0000_0500);
        req_valid = 4'b0001;
        wait_grant("ab", 4'b0001, 32'h0000_0500);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        req_valid = 4'b0000;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {8{32'hDEAD_0500}};
        step();
        mem_resp_valid = 1'b0;
        check("ab_resp_valid", LB'(resp_valid), '0);
        check("ab_busy_resp", LB'(busy), LB'(1'b1));
        step();
        check("ab_idle_busy", LB'(busy), '0);
        check("ab_coalesce_count", LB'(coalesce_count), LB'(16'd1));

        // Stray response in IDLE.
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        check("stray_resp_valid", LB'(resp_valid), '0);
        check("stray_busy", LB'(busy), '0);
        check("stray_mem_req_valid", LB'(mem_req_valid), '0);

        // ---------------- reset in mid-WAIT ----------------
        set_addr(1, 32'h0000_0600);
        req_valid = 4'b0010;
        wait_grant("rw", 4'b0010, 32'h0000_0600);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rw_in_wait_busy", LB'(busy), LB'(1'b1));
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("rw_busy", LB'(busy), '0);
        check("rw_mem_req_valid", LB'(mem_req_valid), '0);
        check("rw_mem_req_addr", LB'(mem_req_addr), '0);
        check("rw_refill_count", LB'(refill_count), '0);
        check("rw_coalesce_count", LB'(coalesce_count), '0);
        check("rw_resp_data", resp_data, '0);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {8{32'hFEED_0600}};
        step();
        mem_resp_valid = 1'b0;
        check("rw_late_resp_valid", LB'(resp_valid), '0);
        check("rw_late_busy", LB'(busy), '0);
        step();
        check("rw_late_resp_valid2", LB'(resp_valid), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
